// File: rtl/hs_rx_pkg.sv
// Shared constants and types for the hs_rx_fifo receiver: default sizing,
// derived pointer/count widths and the per-word handshake state.
package hs_rx_pkg;

  localparam int unsigned DefDataW      = 16;
  localparam int unsigned DefDepth      = 4;
  localparam int unsigned DefSyncStages = 2;

  localparam int unsigned DefPtrW = $clog2(DefDepth);
  localparam int unsigned DefCntW = $clog2(DefDepth) + 1;

  localparam int unsigned StallW = 16;

  typedef enum logic [0:0] {
    StIdle,
    StPending
  } rx_state_e;

endpackage

// File: rtl/hs_rx_fifo_if.sv
// Bundle of the two-phase input handshake and valid/ready output of hs_rx_fifo.
// The slave modport is the receiver; master is the sender/consumer side.
interface hs_rx_fifo_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 4
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic              io_In_HS_Req;
  logic              io_In_HS_Ack;
  logic [DATA_W-1:0] io_In_Data;
  logic              io_Out_Valid;
  logic              io_Out_Ready;
  logic [DATA_W-1:0] io_Out_Data;
  logic [CntW-1:0]   io_Count;

  modport slave (
    input  io_In_HS_Req,
    input  io_In_Data,
    input  io_Out_Ready,
    output io_In_HS_Ack,
    output io_Out_Valid,
    output io_Out_Data,
    output io_Count
  );

  modport master (
    output io_In_HS_Req,
    output io_In_Data,
    output io_Out_Ready,
    input  io_In_HS_Ack,
    input  io_Out_Valid,
    input  io_Out_Data,
    input  io_Count
  );

endinterface

// File: rtl/hs_rx_sync.sv
// Multi-flop synchronizer chain with asynchronous active-high reset to 0.
module hs_rx_sync #(
  parameter int unsigned Stages = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [Stages-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[Stages-2:0], d_i};
    end
  end

  assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/hs_rx_fifo.sv
// Two-phase Req/Ack receiver feeding a small FIFO with a valid/ready output.
// Optional HS_RX_STATS_EN adds io_Stat_Stall, a saturating pending-while-full cycle count.
module hs_rx_fifo
  import hs_rx_pkg::*;
#(
  parameter int unsigned DATA_W      = DefDataW,
  parameter int unsigned DEPTH       = DefDepth,
  parameter int unsigned SYNC_STAGES = DefSyncStages
) (
  input  logic       clock,
  input  logic       reset,
  hs_rx_fifo_if.slave bus
`ifdef HS_RX_STATS_EN
  ,
  output logic [StallW-1:0] io_Stat_Stall
`endif
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic              req_s;
  logic              ack_q, ack_d;
  logic [PtrW-1:0]   head_q, head_d;
  logic [PtrW-1:0]   tail_q, tail_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  rx_state_e state;
  logic      full;
  logic      empty;
  logic      push;
  logic      pop;

  hs_rx_sync #(
    .Stages(SYNC_STAGES)
  ) u_req_sync (
    .clk_i(clock),
    .rst_i(reset),
    .d_i  (bus.io_In_HS_Req),
    .q_o  (req_s)
  );

  always_comb begin
    state   = (req_s != ack_q) ? StPending : StIdle;
    full    = (count_q == CntW'(DEPTH));
    empty   = (count_q == '0);
    // Full is judged before this cycle's pop, so a pop never frees a slot for a same-cycle push.
    push    = (state == StPending) && !full;
    pop     = !empty && bus.io_Out_Ready;
    ack_d   = ack_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) begin
      ack_d  = ~ack_q;
      tail_d = tail_q + PtrW'(1);
    end
    if (pop) begin
      head_d = head_q + PtrW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ack_q   <= 1'b0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      ack_q   <= ack_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: reads are gated by occupancy.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[tail_q] <= bus.io_In_Data;
    end
  end

  assign bus.io_In_HS_Ack = ack_q;
  assign bus.io_Out_Valid = !empty;
  assign bus.io_Out_Data  = empty ? '0 : mem_q[head_q];
  assign bus.io_Count     = count_q;

`ifdef HS_RX_STATS_EN
  logic [StallW-1:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if ((state == StPending) && full && (stall_q != '1)) begin
      stall_d = stall_q + StallW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign io_Stat_Stall = stall_q;
`endif

endmodule

// File: tb/tb_hs_rx_fifo.sv
// Scoreboard bench for hs_rx_fifo: a sender pushes expected words into a queue,
// a negedge monitor pops and compares whenever the DUT hands a word over.
module tb_hs_rx_fifo;

  logic clock;
  logic reset;

  hs_rx_fifo_if #(.DATA_W(16), .DEPTH(4)) bus ();

`ifdef HS_RX_STATS_EN
  logic [15:0] stat_stall;
`endif

  hs_rx_fifo dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
`ifdef HS_RX_STATS_EN
    ,
    .io_Stat_Stall(stat_stall)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [15:0] exp_q[$];
  int unsigned max_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!reset && bus.io_Out_Valid && bus.io_Out_Ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL out_data: got 0x%0h expected nothing (queue empty)", bus.io_Out_Data);
      end else begin
        check("out_data", {16'h0, bus.io_Out_Data}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
    if (32'(bus.io_Count) > max_cnt) max_cnt = 32'(bus.io_Count);
  endtask

  // Toggle Req with a word and wait (bounded) for the matching Ack toggle.
  task automatic send(input logic [15:0] w, output int lat);
    bus.io_In_Data   = w;
    bus.io_In_HS_Req = ~bus.io_In_HS_Req;
    exp_q.push_back(w);
    lat = 0;
    while (bus.io_In_HS_Ack != bus.io_In_HS_Req && lat < 12) begin
      step();
      lat++;
    end
    if (bus.io_In_HS_Ack != bus.io_In_HS_Req) begin
      n_cmp++;
      n_err++;
      $display("FAIL ack_timeout: word 0x%0h got no ack within %0d cycles", w, lat);
    end
  endtask

  task automatic drain();
    bus.io_Out_Ready = 1'b1;
    repeat (10) step();
    bus.io_Out_Ready = 1'b0;
    step();
  endtask

  int lat;
  logic ack_before;

  initial begin
    reset            = 1'b1;
    bus.io_In_HS_Req = 1'b0;
    bus.io_In_Data   = 16'h0;
    bus.io_Out_Ready = 1'b0;
    #1;
    check("rst_ack", {31'h0, bus.io_In_HS_Ack}, 32'h0);
    check("rst_valid", {31'h0, bus.io_Out_Valid}, 32'h0);
    check("rst_data", {16'h0, bus.io_Out_Data}, 32'h0);
    check("rst_count", 32'(bus.io_Count), 32'h0);
    repeat (2) step();
    reset = 1'b0;
    repeat (5) step();
    check("idle_count", 32'(bus.io_Count), 32'h0);
    check("idle_ack", {31'h0, bus.io_In_HS_Ack}, 32'h0);

    // Single word
    send(16'h1234, lat);
    check("single_lat_ok", {31'h0, (lat >= 2 && lat <= 3)}, 32'h1);
    check("single_valid", {31'h0, bus.io_Out_Valid}, 32'h1);
    check("single_data", {16'h0, bus.io_Out_Data}, 32'h1234);
    check("single_count", 32'(bus.io_Count), 32'h1);
    drain();

    // Burst with backpressure: 4 accepted, 5th withheld until a pop
    for (int i = 1; i <= 4; i++) send(16'(i), lat);
    check("burst_count_full", 32'(bus.io_Count), 32'h4);
    ack_before       = bus.io_In_HS_Ack;
    bus.io_In_Data   = 16'h0005;
    bus.io_In_HS_Req = ~bus.io_In_HS_Req;
    exp_q.push_back(16'h0005);
    repeat (10) step();
    check("burst_ack_withheld", {31'h0, bus.io_In_HS_Ack}, {31'h0, ack_before});
    check("burst_count_hold", 32'(bus.io_Count), 32'h4);
    bus.io_Out_Ready = 1'b1;
    step();
    check("burst_pop_count", 32'(bus.io_Count), 32'h3);
    check("burst_ack_still", {31'h0, bus.io_In_HS_Ack}, {31'h0, ack_before});
    step();
    check("burst_ack_late", {31'h0, bus.io_In_HS_Ack}, {31'h0, bus.io_In_HS_Req});
    drain();
    check("burst_drained", 32'(bus.io_Count), 32'h0);
`ifdef HS_RX_STATS_EN
    check("stall_count", {16'h0, stat_stall}, 32'd9);
`endif

    // Wrap-around with the consumer always ready
    bus.io_Out_Ready = 1'b1;
    max_cnt          = 0;
    for (int i = 0; i < 10; i++) send(16'h00A0 + 16'(i), lat);
    repeat (4) step();
    check("wrap_max_count_le2", {31'h0, (max_cnt <= 2)}, 32'h1);
    check("wrap_count_end", 32'(bus.io_Count), 32'h0);
    bus.io_Out_Ready = 1'b0;
    step();

    // Full with a pending word and a single pop: count 4 -> 3 -> 4
    for (int i = 0; i < 4; i++) send(16'h0B00 + 16'(i), lat);
    ack_before       = bus.io_In_HS_Ack;
    bus.io_In_Data   = 16'h0B04;
    bus.io_In_HS_Req = ~bus.io_In_HS_Req;
    exp_q.push_back(16'h0B04);
    repeat (4) step();
    check("fp_count_full", 32'(bus.io_Count), 32'h4);
    bus.io_Out_Ready = 1'b1;
    step();
    bus.io_Out_Ready = 1'b0;
    check("fp_count_after_pop", 32'(bus.io_Count), 32'h3);
    check("fp_ack_not_yet", {31'h0, bus.io_In_HS_Ack}, {31'h0, ack_before});
    step();
    check("fp_count_refill", 32'(bus.io_Count), 32'h4);
    check("fp_ack_toggled", {31'h0, bus.io_In_HS_Ack}, {31'h0, bus.io_In_HS_Req});
    drain();

    // Reset mid-stream with Req held high
    send(16'h0C01, lat);
    send(16'h0C02, lat);
    check("mid_count_pre", 32'(bus.io_Count), 32'h2);
    reset = 1'b1;
    exp_q.delete();
    bus.io_In_HS_Req = 1'b1;
    bus.io_In_Data   = 16'hBEEF;
    #1;
    check("mid_rst_count", 32'(bus.io_Count), 32'h0);
    check("mid_rst_ack", {31'h0, bus.io_In_HS_Ack}, 32'h0);
    repeat (2) step();
    reset = 1'b0;
    exp_q.push_back(16'hBEEF);
    lat = 0;
    while (bus.io_In_HS_Ack != 1'b1 && lat < 12) begin
      step();
      lat++;
    end
    check("mid_ack_high", {31'h0, bus.io_In_HS_Ack}, 32'h1);
    check("mid_count_one", 32'(bus.io_Count), 32'h1);
    check("mid_data", {16'h0, bus.io_Out_Data}, 32'hBEEF);
    drain();
    check("sb_empty", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1);
  end

endmodule
